// File: rtl/vga_pkg.sv
// Shared constants, FSM state type and per-axis bounce helper for the box sprite renderer.
// Optional screen border is enabled in the top level by defining SCREEN_BORDER_EN.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    localparam logic [11:0] COLOR_BG    = 12'h00F;
    localparam logic [11:0] COLOR_BOX   = 12'hF00;
    localparam logic [11:0] COLOR_FLASH = 12'hFFF;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        FLASH = 2'd2
    } state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
        logic       bounce;
    } axis_t;

    // One frame step along one axis; dir=1 means increasing coordinate. 11-bit math avoids wrap.
    function automatic axis_t step_axis(input logic [9:0]  pos,
                                        input logic        dir,
                                        input logic [10:0] lim,
                                        input logic [10:0] step);
        axis_t       res;
        logic [10:0] sum;
        sum        = {1'b0, pos} + step;
        res.pos    = pos;
        res.dir    = dir;
        res.bounce = 1'b0;
        if (dir) begin
            if (sum >= lim) begin
                res.pos    = lim[9:0];
                res.dir    = 1'b0;
                res.bounce = 1'b1;
            end else begin
                res.pos = sum[9:0];
            end
        end else if ({1'b0, pos} <= step) begin
            res.pos    = '0;
            res.dir    = 1'b1;
            res.bounce = 1'b1;
        end else begin
            res.pos = pos - step[9:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/box_motion.sv
// Sprite motion controller: run/stop FSM, bouncing position, flash frame counter and hit pulse.
//
// state | meaning
// IDLE  | position frozen, waiting for start
// MOVE  | stepping once per frame_tick, normal sprite colour
// FLASH | stepping, sprite shows flash colour until flash_cnt expires
module box_motion
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int BOX_SIZE     = 32,
    parameter int STEP         = 4,
    parameter int FLASH_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       stop,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output state_t     state,
    output logic       hit
);

    localparam int          FW         = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES - 1);
    localparam logic [10:0] X_LIM      = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_LIM      = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP_W     = 11'(STEP);
    localparam logic [9:0]  X_HOME     = 10'((H_ACTIVE - BOX_SIZE) / 2);
    localparam logic [9:0]  Y_HOME     = 10'((V_ACTIVE - BOX_SIZE) / 2);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [9:0]    r_box_x;
    logic [9:0]    r_box_y;
    logic          r_dir_x;
    logic          r_dir_y;
    logic [FW-1:0] r_flash_cnt;
    logic [FW-1:0] w_flash_nxt;
    logic          r_hit;
    logic          w_update;
    logic          w_bounce;
    axis_t         w_ax;
    axis_t         w_ay;

    // stop outranks both start and frame_tick
    assign w_update = frame_tick && !stop && (r_state != IDLE);

    always_comb begin
        w_ax     = step_axis(r_box_x, r_dir_x, X_LIM, STEP_W);
        w_ay     = step_axis(r_box_y, r_dir_y, Y_LIM, STEP_W);
        w_bounce = w_update && (w_ax.bounce || w_ay.bounce);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_box_x     <= X_HOME;
            r_box_y     <= Y_HOME;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_flash_cnt <= '0;
            r_hit       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flash_cnt <= w_flash_nxt;
            r_hit       <= w_bounce;
            if (w_update) begin
                r_box_x <= w_ax.pos;
                r_box_y <= w_ay.pos;
                r_dir_x <= w_ax.dir;
                r_dir_y <= w_ay.dir;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start && !stop) w_state_nxt = MOVE;
            MOVE: begin
                if (stop)          w_state_nxt = IDLE;
                else if (w_bounce) w_state_nxt = FLASH;
            end
            FLASH: begin
                if (stop)
                    w_state_nxt = IDLE;
                else if (w_update && !w_bounce && (r_flash_cnt == '0))
                    w_state_nxt = MOVE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_flash_nxt = r_flash_cnt;
        if (stop)
            w_flash_nxt = '0;
        else if (w_bounce)
            w_flash_nxt = FLASH_LOAD;
        else if ((r_state == FLASH) && w_update && (r_flash_cnt != '0))
            w_flash_nxt = r_flash_cnt - 1'b1;
    end

    assign box_x = r_box_x;
    assign box_y = r_box_y;
    assign state = r_state;
    assign hit   = r_hit;

endmodule

// File: rtl/box_sprite_renderer.sv
// Pixel colour source: bouncing square sprite over a background, 2-cycle registered pipeline.
// Define SCREEN_BORDER_EN to draw a white one-pixel frame around the active area.
module box_sprite_renderer
    import vga_pkg::*;
#(
    parameter int          H_ACTIVE     = H_ACTIVE_DEF,
    parameter int          V_ACTIVE     = V_ACTIVE_DEF,
    parameter int          BOX_SIZE     = 32,
    parameter int          STEP         = 4,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] BG_COLOR     = COLOR_BG,
    parameter logic [11:0] BOX_COLOR    = COLOR_BOX,
    parameter logic [11:0] FLASH_COLOR  = COLOR_FLASH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        video_on,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        stop,
    output logic [11:0] rgb,
    output logic        hit
);

    localparam logic [10:0] BOX_W = 11'(BOX_SIZE);

    logic [9:0]  w_box_x;
    logic [9:0]  w_box_y;
    state_t      w_state;
    logic        w_in_box;
    logic [11:0] w_color;
    logic        r_s1_video;
    logic        r_s1_in_box;
    logic [11:0] r_rgb;

    box_motion #(
        .H_ACTIVE     (H_ACTIVE),
        .V_ACTIVE     (V_ACTIVE),
        .BOX_SIZE     (BOX_SIZE),
        .STEP         (STEP),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_motion (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .stop       (stop),
        .box_x      (w_box_x),
        .box_y      (w_box_y),
        .state      (w_state),
        .hit        (hit)
    );

    assign w_in_box = ({1'b0, pixel_x} >= {1'b0, w_box_x}) &&
                      ({1'b0, pixel_x} <  ({1'b0, w_box_x} + BOX_W)) &&
                      ({1'b0, pixel_y} >= {1'b0, w_box_y}) &&
                      ({1'b0, pixel_y} <  ({1'b0, w_box_y} + BOX_W));

`ifdef SCREEN_BORDER_EN
    logic w_border;
    logic r_s1_border;

    assign w_border = (pixel_x == 10'd0) || (pixel_x == 10'(H_ACTIVE - 1)) ||
                      (pixel_y == 10'd0) || (pixel_y == 10'(V_ACTIVE - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_s1_border <= 1'b0;
        else        r_s1_border <= w_border;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_video  <= 1'b0;
            r_s1_in_box <= 1'b0;
        end else begin
            r_s1_video  <= video_on;
            r_s1_in_box <= w_in_box;
        end
    end

    // Stage 2 uses the live FSM state so the flash colour tracks the frame it belongs to
    always_comb begin
        w_color = BG_COLOR;
        if (!r_s1_video)
            w_color = 12'h000;
`ifdef SCREEN_BORDER_EN
        else if (r_s1_border)
            w_color = COLOR_WHITE;
`endif
        else if (r_s1_in_box && (w_state == FLASH))
            w_color = FLASH_COLOR;
        else if (r_s1_in_box)
            w_color = BOX_COLOR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rgb <= 12'h000;
        else        r_rgb <= w_color;
    end

    assign rgb = r_rgb;

endmodule

// File: tb/tb_box_sprite_renderer.sv
// Self-checking bench for box_sprite_renderer: per-cycle model compare plus directed literal checks.
// Border checks are included when SCREEN_BORDER_EN is defined.
module tb_box_sprite_renderer;

    logic        clk;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        video_on, frame_tick, start, stop;
    logic [11:0] rgb;
    logic        hit;

    logic        start2, tick2;
    logic [11:0] rgb2;
    logic        hit2;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 0;

    box_sprite_renderer dut (
        .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .frame_tick(frame_tick), .start(start), .stop(stop),
        .rgb(rgb), .hit(hit)
    );

    // Square screen: both axes reach their walls on the same frame
    box_sprite_renderer #(.H_ACTIVE(480), .V_ACTIVE(480)) dut2 (
        .clk(clk), .reset(reset), .pixel_x(10'd0), .pixel_y(10'd0),
        .video_on(1'b0), .frame_tick(tick2), .start(start2), .stop(1'b0),
        .rgb(rgb2), .hit(hit2)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: sprite geometry, bounce rules and colour choice, one frame step per tick
    int m_bx, m_by, m_dx, m_dy, m_mode, m_fc;
    int m_rgb, m_hit;
    bit m_s1v, m_s1in, m_s1b;

    function automatic int colour_of(bit v, bit inb, bit brd, int mode);
        if (!v) return 0;
        if (brd) return 'hFFF;
        if (inb) return (mode == 2) ? 'hFFF : 'hF00;
        return 'h00F;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_bx = 304; m_by = 224; m_dx = 1; m_dy = 1; m_mode = 0; m_fc = 0;
                m_rgb = 0; m_hit = 0; m_s1v = 0; m_s1in = 0; m_s1b = 0;
            end else begin
                bit bnc;
                m_rgb  = colour_of(m_s1v, m_s1in, m_s1b, m_mode);
                m_s1v  = video_on;
                m_s1in = (int'(pixel_x) >= m_bx) && (int'(pixel_x) < m_bx + 32) &&
                         (int'(pixel_y) >= m_by) && (int'(pixel_y) < m_by + 32);
`ifdef SCREEN_BORDER_EN
                m_s1b  = (pixel_x == 0) || (pixel_x == 639) || (pixel_y == 0) || (pixel_y == 479);
`else
                m_s1b  = 0;
`endif
                m_hit = 0;
                if (m_mode != 0 && stop) begin
                    m_mode = 0; m_fc = 0;
                end else if (m_mode == 0) begin
                    if (start && !stop) m_mode = 1;
                end else if (frame_tick) begin
                    bnc = 0;
                    if (m_dx > 0) begin
                        if (m_bx + 4 >= 608) begin m_bx = 608; m_dx = -1; bnc = 1; end
                        else m_bx += 4;
                    end else begin
                        if (m_bx <= 4) begin m_bx = 0; m_dx = 1; bnc = 1; end
                        else m_bx -= 4;
                    end
                    if (m_dy > 0) begin
                        if (m_by + 4 >= 448) begin m_by = 448; m_dy = -1; bnc = 1; end
                        else m_by += 4;
                    end else begin
                        if (m_by <= 4) begin m_by = 0; m_dy = 1; bnc = 1; end
                        else m_by -= 4;
                    end
                    if (bnc) begin
                        m_mode = 2; m_fc = 7; m_hit = 1;
                    end else if (m_mode == 2) begin
                        if (m_fc == 0) m_mode = 1;
                        else m_fc--;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("model_rgb", int'(rgb), m_rgb);
                chk("model_hit", int'(hit), m_hit);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_px(input string name, input int x, input int y, input bit vo, input int exp);
        @(negedge clk);
        pixel_x = 10'(x); pixel_y = 10'(y); video_on = vo;
        repeat (2) @(negedge clk);
        chk(name, int'(rgb), exp);
    endtask

    task automatic tick();
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        idle(1);
    endtask

    task automatic tick_hit(input string name, input int exp);
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        chk({name, "_pulse"}, int'(hit), exp);
        @(negedge clk);
        chk({name, "_clear"}, int'(hit), 0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic chk_pos(input string name, input int x, input int y);
        chk({name, "_x"}, int'(dut.w_box_x), x);
        chk({name, "_y"}, int'(dut.w_box_y), y);
    endtask

    initial begin
        int hits2;
        reset = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b1;
        frame_tick = 1'b0; start = 1'b0; stop = 1'b0; start2 = 1'b0; tick2 = 1'b0;
        idle(4);
        chk("reset_rgb", int'(rgb), 0);
        chk("reset_hit", int'(hit), 0);
        chk_pos("reset_pos", 304, 224);
        #2 reset = 1'b1;
        chk_on = 1;

        expect_px("bg_origin", 0, 0, 1, 'h00F);
        expect_px("box_topleft", 304, 224, 1, 'hF00);
        expect_px("box_right_edge_out", 336, 224, 1, 'h00F);
        expect_px("box_bottomright_in", 335, 255, 1, 'hF00);
        expect_px("box_bottom_edge_out", 304, 256, 1, 'h00F);
        expect_px("box_left_edge_out", 303, 230, 1, 'h00F);
        expect_px("blank_inside_box", 310, 230, 0, 0);

        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        tick();
        chk_pos("start_stop_same", 304, 224);

        pulse_start();
        repeat (3) tick();
        chk_pos("three_ticks", 316, 236);
        expect_px("moved_box", 316, 236, 1, 'hF00);
        expect_px("moved_box_left_out", 315, 236, 1, 'h00F);

        @(negedge clk); stop = 1'b1; frame_tick = 1'b1;
        @(negedge clk); stop = 1'b0; frame_tick = 1'b0;
        chk_pos("stop_tick_same", 316, 236);
        tick();
        chk_pos("idle_tick", 316, 236);

        pulse_start();
        repeat (72) tick();
        chk_pos("before_wall", 604, 372);
        tick_hit("right_wall_hit", 1);
        chk_pos("at_wall", 608, 368);
        expect_px("flash_first", 608, 368, 1, 'hFFF);
        tick_hit("after_wall_nohit", 0);
        chk_pos("after_wall", 604, 364);
        repeat (6) tick();
        expect_px("flash_last", 580, 340, 1, 'hFFF);
        tick();
        expect_px("flash_over", 576, 336, 1, 'hF00);
        expect_px("flash_over_bg", 575, 336, 1, 'h00F);

        expect_px("pre_reset_box", 580, 340, 1, 'hF00);
        @(negedge clk); #2 reset = 1'b0;
        #1 chk("reset_midframe_rgb", int'(rgb), 0);
        idle(2);
        #2 reset = 1'b1;
        chk_pos("post_reset_pos", 304, 224);
        expect_px("post_reset_bg", 0, 0, 1, 'h00F);

        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        repeat (55) begin
            @(negedge clk); tick2 = 1'b1;
            @(negedge clk); tick2 = 1'b0;
        end
        chk("corner_pre_x", int'(dut2.w_box_x), 444);
        chk("corner_pre_y", int'(dut2.w_box_y), 444);
        hits2 = 0;
        @(negedge clk); tick2 = 1'b1;
        @(negedge clk); tick2 = 1'b0;
        repeat (4) begin
            if (hit2) hits2++;
            @(negedge clk);
        end
        chk("corner_hit_count", hits2, 1);
        chk("corner_x", int'(dut2.w_box_x), 448);
        chk("corner_y", int'(dut2.w_box_y), 448);
        @(negedge clk); tick2 = 1'b1;
        @(negedge clk); tick2 = 1'b0;
        chk("corner_after_x", int'(dut2.w_box_x), 444);
        chk("corner_after_y", int'(dut2.w_box_y), 444);
        chk("corner_after_hit", int'(hit2), 0);
        chk("dut2_blank_rgb", int'(rgb2), 0);

`ifdef SCREEN_BORDER_EN
        expect_px("border_right", 639, 100, 1, 'hFFF);
        expect_px("border_top_over_box", 320, 0, 1, 'hFFF);
        expect_px("border_blank", 639, 100, 0, 0);
`else
        expect_px("no_border_right", 639, 100, 1, 'h00F);
`endif

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
